// File: rtl/riscv_em_stall_ctrl.sv
// riscv_em_stall_ctrl: stall/flush sequencer for the execute-to-memory boundary.
// Turns multi-cycle events (iterative mul/div in E, memory wait in M, traps in M)
// into per-cycle hold and flush controls for the F/D, D/E, E/M and M/W registers.
//
// Ports:
//   i_riscv_sc_clk / i_riscv_sc_rst_n : clock, asynchronous active-low reset
//   i_riscv_sc_div_start_e            : multi-cycle mul/div present in E (level)
//   i_riscv_sc_div_done               : mul/div result valid this cycle
//   i_riscv_sc_mem_req_m              : load/store present in M
//   i_riscv_sc_mem_ack                : memory completes the M access this cycle
//   i_riscv_sc_trap_m                 : trap taken by the instruction in M
//   i_riscv_sc_cnt_clr                : synchronous clear of the stall counter
//   o_riscv_sc_stall_fd/de/em         : hold F/D, D/E, E/M registers
//   o_riscv_sc_flush_de/em/mw         : flush D/E, E/M, M/W registers
//   o_riscv_sc_busy                   : registered, high while in a wait state
//   o_riscv_sc_timeout                : one-cycle watchdog abort pulse
//   o_riscv_sc_stall_cnt              : saturating count of F/D stall cycles
//
// Optional watchdog: define RISCV_SC_TIMEOUT_EN to abort waits longer than
// TIMEOUT cycles (treated as a trap). Without it o_riscv_sc_timeout is 0.

module riscv_em_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             i_riscv_sc_clk,
    input  logic             i_riscv_sc_rst_n,
    input  logic             i_riscv_sc_div_start_e,
    input  logic             i_riscv_sc_div_done,
    input  logic             i_riscv_sc_mem_req_m,
    input  logic             i_riscv_sc_mem_ack,
    input  logic             i_riscv_sc_trap_m,
    input  logic             i_riscv_sc_cnt_clr,
    output logic             o_riscv_sc_stall_fd,
    output logic             o_riscv_sc_stall_de,
    output logic             o_riscv_sc_stall_em,
    output logic             o_riscv_sc_flush_de,
    output logic             o_riscv_sc_flush_em,
    output logic             o_riscv_sc_flush_mw,
    output logic             o_riscv_sc_busy,
    output logic             o_riscv_sc_timeout,
    output logic [CNT_W-1:0] o_riscv_sc_stall_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        DIV_WAIT   = 2'd2,
        TRAP_DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic mem_stall;
    logic div_stall;
    logic wd_fire;
    logic in_wait;
    logic wait_nxt;

    logic stall_fd;
    logic stall_de;
    logic stall_em;
    logic flush_de;
    logic flush_em;
    logic flush_mw;
    logic timeout;

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    assign mem_stall = i_riscv_sc_mem_req_m & ~i_riscv_sc_mem_ack;
    assign div_stall = i_riscv_sc_div_start_e & ~i_riscv_sc_div_done;
    assign in_wait   = (state == MEM_WAIT) || (state == DIV_WAIT);
    assign wait_nxt  = (state_nxt == MEM_WAIT) || (state_nxt == DIV_WAIT);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef RISCV_SC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    // Holds the 1-based index of the current wait cycle, so the abort
    // lands in the TIMEOUT-th cycle spent waiting.
    logic [WD_W-1:0] wd_cnt;
    logic            wait_open;
    logic            enter_wait;

    assign wait_open = ((state == MEM_WAIT) && !i_riscv_sc_mem_ack)
                    || ((state == DIV_WAIT) && !i_riscv_sc_div_done);
    assign wd_fire    = wait_open && (wd_cnt == WD_MAX);
    assign enter_wait = wait_nxt && (state_nxt != state);

    always_ff @(posedge i_riscv_sc_clk or negedge i_riscv_sc_rst_n) begin
        if (!i_riscv_sc_rst_n) begin
            wd_cnt <= '0;
        end else if (enter_wait) begin
            wd_cnt <= WD_W'(1);
        end else if (in_wait && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_riscv_sc_clk or negedge i_riscv_sc_rst_n) begin
        if (!i_riscv_sc_rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Mealy stall/flush outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        stall_fd  = 1'b0;
        stall_de  = 1'b0;
        stall_em  = 1'b0;
        flush_de  = 1'b0;
        flush_em  = 1'b0;
        flush_mw  = 1'b0;
        timeout   = 1'b0;

        if (i_riscv_sc_trap_m || wd_fire) begin
            flush_de  = 1'b1;
            flush_em  = 1'b1;
            flush_mw  = 1'b1;
            timeout   = ~i_riscv_sc_trap_m;
            state_nxt = TRAP_DRAIN;
        end else begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    // In MEM_WAIT the request is implied; only ack matters.
                    if ((state == MEM_WAIT) ? !i_riscv_sc_mem_ack
                                            : mem_stall) begin
                        stall_fd  = 1'b1;
                        stall_de  = 1'b1;
                        stall_em  = 1'b1;
                        flush_mw  = 1'b1;
                        state_nxt = MEM_WAIT;
                    end else if (div_stall) begin
                        stall_fd  = 1'b1;
                        stall_de  = 1'b1;
                        flush_em  = 1'b1;
                        state_nxt = DIV_WAIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                DIV_WAIT: begin
                    // M holds a bubble here, so mem_req is not consulted.
                    if (!i_riscv_sc_div_done) begin
                        stall_fd = 1'b1;
                        stall_de = 1'b1;
                        flush_em = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                TRAP_DRAIN: begin
                    // Bubble while fetch redirects to the handler.
                    flush_de  = 1'b1;
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is asserted.
    assign o_riscv_sc_stall_fd = stall_fd & i_riscv_sc_rst_n;
    assign o_riscv_sc_stall_de = stall_de & i_riscv_sc_rst_n;
    assign o_riscv_sc_stall_em = stall_em & i_riscv_sc_rst_n;
    assign o_riscv_sc_flush_de = flush_de & i_riscv_sc_rst_n;
    assign o_riscv_sc_flush_em = flush_em & i_riscv_sc_rst_n;
    assign o_riscv_sc_flush_mw = flush_mw & i_riscv_sc_rst_n;
    assign o_riscv_sc_timeout  = timeout  & i_riscv_sc_rst_n;

    // ------------------------------------------------------------------
    // Busy flag: mirrors the wait states one register stage later
    // ------------------------------------------------------------------
    always_ff @(posedge i_riscv_sc_clk or negedge i_riscv_sc_rst_n) begin
        if (!i_riscv_sc_rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= wait_nxt;
        end
    end

    assign o_riscv_sc_busy = busy_q;

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_riscv_sc_clk or negedge i_riscv_sc_rst_n) begin
        if (!i_riscv_sc_rst_n) begin
            cnt_q <= '0;
        end else if (i_riscv_sc_cnt_clr) begin
            cnt_q <= '0;
        end else if (stall_fd && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_riscv_sc_stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_em_stall_ctrl.sv
// tb_riscv_em_stall_ctrl: self-checking bench for riscv_em_stall_ctrl.
// Table vectors, hand sequences for multi-cycle cases, then random vs. model.

module tb_riscv_em_stall_ctrl;

`ifdef RISCV_SC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_MAIN = 255;

    logic clk = 1'b0;
    logic rst_n;
    logic req, ack, st, dn, tr, clr;
    logic fd, de, em, fde, fem, fmw, busy, to;
    logic [31:0] cnt;
    logic [6:0] outv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign outv = {fd, de, em, fde, fem, fmw, to};

    riscv_em_stall_ctrl #(.TIMEOUT(TO_MAIN), .CNT_W(32)) dut (
        .i_riscv_sc_clk        (clk),
        .i_riscv_sc_rst_n      (rst_n),
        .i_riscv_sc_div_start_e(st),
        .i_riscv_sc_div_done   (dn),
        .i_riscv_sc_mem_req_m  (req),
        .i_riscv_sc_mem_ack    (ack),
        .i_riscv_sc_trap_m     (tr),
        .i_riscv_sc_cnt_clr    (clr),
        .o_riscv_sc_stall_fd   (fd),
        .o_riscv_sc_stall_de   (de),
        .o_riscv_sc_stall_em   (em),
        .o_riscv_sc_flush_de   (fde),
        .o_riscv_sc_flush_em   (fem),
        .o_riscv_sc_flush_mw   (fmw),
        .o_riscv_sc_busy       (busy),
        .o_riscv_sc_timeout    (to),
        .o_riscv_sc_stall_cnt  (cnt)
    );

`ifdef RISCV_SC_TIMEOUT_EN
    logic w_fd, w_de, w_em, w_fde, w_fem, w_fmw, w_busy, w_to;
    logic [7:0] w_cnt;
    logic [6:0] w_outv;
    assign w_outv = {w_fd, w_de, w_em, w_fde, w_fem, w_fmw, w_to};

    riscv_em_stall_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut_wd (
        .i_riscv_sc_clk        (clk),
        .i_riscv_sc_rst_n      (rst_n),
        .i_riscv_sc_div_start_e(st),
        .i_riscv_sc_div_done   (dn),
        .i_riscv_sc_mem_req_m  (req),
        .i_riscv_sc_mem_ack    (ack),
        .i_riscv_sc_trap_m     (tr),
        .i_riscv_sc_cnt_clr    (clr),
        .o_riscv_sc_stall_fd   (w_fd),
        .o_riscv_sc_stall_de   (w_de),
        .o_riscv_sc_stall_em   (w_em),
        .o_riscv_sc_flush_de   (w_fde),
        .o_riscv_sc_flush_em   (w_fem),
        .o_riscv_sc_flush_mw   (w_fmw),
        .o_riscv_sc_busy       (w_busy),
        .o_riscv_sc_timeout    (w_to),
        .o_riscv_sc_stall_cnt  (w_cnt)
    );
`endif

    // Expected output patterns {fd,de,em,fde,fem,fmw,to}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_MEM  = 7'b1110010;
    localparam logic [6:0] E_DIV  = 7'b1100100;
    localparam logic [6:0] E_TRAP = 7'b0001110;
    localparam logic [6:0] E_WDOG = 7'b0001111;
    localparam logic [6:0] E_DRN  = 7'b0001000;

    typedef struct {
        logic [5:0]  in;   // {req,ack,start,done,trap,clr}
        logic [6:0]  e;
        logic        b;
        logic [31:0] c;
    } vec_t;

    vec_t tbl[17];

    task automatic drive(input logic [5:0] in);
        {req, ack, st, dn, tr, clr} = in;
    endtask

    task automatic chk(input string nm, input logic [6:0] e,
                       input logic eb, input logic [31:0] ec);
        checks++;
        if (outv !== e) begin
            errors++;
            $display("FAIL %s outs got=%b exp=%b", nm, outv, e);
        end
        checks++;
        if (busy !== eb) begin
            errors++;
            $display("FAIL %s busy got=%b exp=%b", nm, busy, eb);
        end
        checks++;
        if (cnt !== ec) begin
            errors++;
            $display("FAIL %s cnt got=%0d exp=%0d", nm, cnt, ec);
        end
    endtask

    // Called at a negedge: drive, check mid-low-phase, advance one cycle.
    task automatic cyc(input string nm, input logic [5:0] in,
                       input logic [6:0] e, input logic eb,
                       input logic [31:0] ec);
        drive(in);
        #1;
        chk(nm, e, eb, ec);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(6'b000000);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference model: phase 0 idle, 1 memory outstanding, 2 divide
    // outstanding, 3 redirect bubble after a trap.
    function automatic void model(input int ph, input int wd,
                                  input logic [5:0] in,
                                  output logic [6:0] e, output int nph);
        logic r, a, s, d, t;
        logic mem_open, div_open, waiting;
        {r, a, s, d, t} = in[5:1];
        e = E_NONE;
        nph = 0;
        mem_open = (ph == 1 || (ph == 0 && r)) && !a;
        div_open = s && !d;
        waiting  = (ph == 1 && !a) || (ph == 2 && !d);
        if (t) begin
            e = E_TRAP;
            nph = 3;
        end else if (TO_EN && waiting && wd == TO_MAIN) begin
            e = E_WDOG;
            nph = 3;
        end else if (ph == 3) begin
            e = E_DRN;
        end else if (ph == 2) begin
            if (!d) begin
                e = E_DIV;
                nph = 2;
            end
        end else if (mem_open) begin
            e = E_MEM;
            nph = 1;
        end else if (div_open) begin
            e = E_DIV;
            nph = 2;
        end
    endfunction

    initial begin
        logic [6:0] e;
        logic [5:0] in;
        int ph, nph, wd;
        logic [31:0] mcnt;

        tbl[0]  = '{6'b100000, E_MEM,  1'b0, 32'd0};
        tbl[1]  = '{6'b100000, E_MEM,  1'b1, 32'd1};
        tbl[2]  = '{6'b100000, E_MEM,  1'b1, 32'd2};
        tbl[3]  = '{6'b110000, E_NONE, 1'b1, 32'd3};
        tbl[4]  = '{6'b000001, E_NONE, 1'b0, 32'd3};
        tbl[5]  = '{6'b001000, E_DIV,  1'b0, 32'd0};
        tbl[6]  = '{6'b001000, E_DIV,  1'b1, 32'd1};
        tbl[7]  = '{6'b001000, E_DIV,  1'b1, 32'd2};
        tbl[8]  = '{6'b001000, E_DIV,  1'b1, 32'd3};
        tbl[9]  = '{6'b001000, E_DIV,  1'b1, 32'd4};
        tbl[10] = '{6'b001100, E_NONE, 1'b1, 32'd5};
        tbl[11] = '{6'b000000, E_NONE, 1'b0, 32'd5};
        tbl[12] = '{6'b110000, E_NONE, 1'b0, 32'd5};
        tbl[13] = '{6'b001100, E_NONE, 1'b0, 32'd5};
        tbl[14] = '{6'b100010, E_TRAP, 1'b0, 32'd5};
        tbl[15] = '{6'b000000, E_DRN,  1'b0, 32'd5};
        tbl[16] = '{6'b000000, E_NONE, 1'b0, 32'd5};

        // Reset with every input high
        rst_n = 1'b0;
        drive(6'b111111);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_hold", E_NONE, 1'b0, 32'd0);
        @(negedge clk);
        drive(6'b000000);
        rst_n = 1'b1;
        #1;
        chk("reset_rel", E_NONE, 1'b0, 32'd0);
        @(negedge clk);

        // Memory wait, divide, same-cycle completions, trap in RUN
        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].in, tbl[i].e,
                tbl[i].b, tbl[i].c);
        end

        // Overlap: memory then divide
        cyc("ovl0", 6'b101000, E_MEM,  1'b0, 32'd5);
        cyc("ovl1", 6'b101000, E_MEM,  1'b1, 32'd6);
        cyc("ovl2", 6'b111000, E_DIV,  1'b1, 32'd7);
        cyc("ovl3", 6'b001000, E_DIV,  1'b1, 32'd8);
        cyc("ovl4", 6'b001000, E_DIV,  1'b1, 32'd9);
        cyc("ovl5", 6'b001000, E_DIV,  1'b1, 32'd10);
        cyc("ovl6", 6'b001100, E_NONE, 1'b1, 32'd11);
        cyc("ovl7", 6'b000000, E_NONE, 1'b0, 32'd11);

        // Trap on the 2nd MEM_WAIT cycle
        cyc("trp0", 6'b100000, E_MEM,  1'b0, 32'd11);
        cyc("trp1", 6'b100000, E_MEM,  1'b1, 32'd12);
        cyc("trp2", 6'b100010, E_TRAP, 1'b1, 32'd13);
        cyc("trp3", 6'b000000, E_DRN,  1'b0, 32'd13);
        cyc("trp4", 6'b000000, E_NONE, 1'b0, 32'd13);

        // Asynchronous reset in the middle of a memory wait
        cyc("arst0", 6'b100000, E_MEM, 1'b0, 32'd13);
        drive(6'b100000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mid", E_NONE, 1'b0, 32'd0);
        @(negedge clk);
        drive(6'b000000);
        rst_n = 1'b1;
        #1;
        chk("arst_rel", E_NONE, 1'b0, 32'd0);
        @(negedge clk);

`ifdef RISCV_SC_TIMEOUT_EN
        // Watchdog with TIMEOUT=4: abort in the 4th MEM_WAIT cycle
        for (int i = 0; i < 6; i++) begin
            drive(6'b100000);
            #1;
            e = (i < 4) ? E_MEM : ((i == 4) ? E_WDOG : E_DRN);
            checks++;
            if (w_outv !== e) begin
                errors++;
                $display("FAIL wdog%0d outs got=%b exp=%b", i, w_outv, e);
            end
            @(negedge clk);
        end
        do_reset();
`endif

        // Random stimulus against the model
        ph = 0;
        wd = 0;
        mcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            in[5] = ($urandom_range(0, 99) < 45) && (ph != 2);
            in[4] = ($urandom_range(0, 99) < 35);
            in[3] = ($urandom_range(0, 99) < 45);
            in[2] = ($urandom_range(0, 99) < 30);
            in[1] = ($urandom_range(0, 99) < 5);
            in[0] = ($urandom_range(0, 99) < 3);
            drive(in);
            #1;
            model(ph, wd, in, e, nph);
            chk($sformatf("rand%0d", n), e, (ph == 1 || ph == 2), mcnt);
            if (in[0]) mcnt = 0;
            else if (e[6] && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
            if ((nph == 1 || nph == 2) && nph != ph) wd = 1;
            else if (nph == ph && (ph == 1 || ph == 2)) wd = wd + 1;
            ph = nph;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
